// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial add sequencer: the FSM state
// encodings and the default Hack datapath width.
package serial_adder_ctrl_pkg;

  localparam int HACK_WIDTH = 16;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_RUN  = 2'd1,
    SA_DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/halfadder.sv
// Half adder primitive: sum = a ^ b, carry = a & b.
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  // Pure combinational half-add
  always_comb begin
    sum   = a ^ b;
    carry = a & b;
  end

endmodule

// File: rtl/serial_fa_cell.sv
// One-bit full adder made from two halfadder instances and an OR gate.
// This is the single adder cell the serial sequencer time-multiplexes.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;
  logic g0;
  logic g1;

  // First stage: propagate (a^b) and generate (a&b)
  halfadder u_ha0 (
    .a     (a),
    .b     (b),
    .sum   (p),
    .carry (g0)
  );

  // Second stage: fold in the incoming carry
  halfadder u_ha1 (
    .a     (p),
    .b     (cin),
    .sum   (s),
    .carry (g1)
  );

  // Carry out is set by either stage generating a carry
  always_comb begin
    cout = g0 | g1;
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer. Two WIDTH-bit operands are accepted on a
// start/ready handshake and added LSB first, one bit per clock, through a
// single serial_fa_cell. The result and carry are registered on the last
// RUN edge and held until the next completion.
// Optional feature: define SERIAL_ADD_OVF_EN to add the signed overflow
// output ovf (carry into MSB xor carry out of MSB).
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = HACK_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  sa_state_t        state_reg, state_next;
  logic [WIDTH-1:0] op_a_reg, op_a_next;
  logic [WIDTH-1:0] op_b_reg, op_b_next;
  // Holds the WIDTH-1 bits already produced; the final bit comes straight
  // from the adder cell when sum is loaded.
  logic [WIDTH-2:0] acc_reg, acc_next;
  logic [WIDTH-2:0] acc_shift;
  logic             carry_reg, carry_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             cout_reg, cout_next;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_reg, ovf_next;
`endif

  logic fa_s;
  logic fa_c;

  // The single shared full-adder cell works on the current LSBs
  serial_fa_cell u_fa (
    .a    (op_a_reg[0]),
    .b    (op_b_reg[0]),
    .cin  (carry_reg),
    .s    (fa_s),
    .cout (fa_c)
  );

  // New bit enters the accumulator MSB; a 1-bit accumulator just reloads
  generate
    if (WIDTH == 2) begin : g_acc_one
      always_comb acc_shift = fa_s;
    end else begin : g_acc_multi
      always_comb acc_shift = {fa_s, acc_reg[WIDTH-2:1]};
    end
  endgenerate

  // Next-state and datapath update for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_next = state_reg;
    op_a_next  = op_a_reg;
    op_b_next  = op_b_reg;
    acc_next   = acc_reg;
    carry_next = carry_reg;
    cnt_next   = cnt_reg;
    sum_next   = sum_reg;
    cout_next  = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
    ovf_next   = ovf_reg;
`endif
    unique case (state_reg)
      SA_IDLE: begin
        if (start) begin
          state_next = SA_RUN;
          op_a_next  = a;
          op_b_next  = b;
          acc_next   = '0;
          carry_next = 1'b0;
          cnt_next   = '0;
        end
      end
      SA_RUN: begin
        op_a_next  = op_a_reg >> 1;
        op_b_next  = op_b_reg >> 1;
        acc_next   = acc_shift;
        carry_next = fa_c;
        cnt_next   = cnt_reg + CNT_W'(1);
        if (cnt_reg == CNT_LAST) begin
          sum_next   = {fa_s, acc_reg};
          cout_next  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          // carry_reg is the carry into the MSB on this final edge
          ovf_next   = carry_reg ^ fa_c;
`endif
          state_next = SA_DONE;
        end
      end
      SA_DONE: begin
        state_next = SA_IDLE;
      end
      default: begin
        state_next = SA_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= SA_IDLE;
      op_a_reg  <= '0;
      op_b_reg  <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      cout_reg  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      op_a_reg  <= op_a_next;
      op_b_reg  <= op_b_next;
      acc_reg   <= acc_next;
      carry_reg <= carry_next;
      cnt_reg   <= cnt_next;
      sum_reg   <= sum_next;
      cout_reg  <= cout_next;
`ifdef SERIAL_ADD_OVF_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  // Handshake flags decode straight from the registered state
  always_comb begin
    ready = (state_reg == SA_IDLE);
    busy  = (state_reg == SA_RUN);
    done  = (state_reg == SA_DONE);
    sum   = sum_reg;
    cout  = cout_reg;
`ifdef SERIAL_ADD_OVF_EN
    ovf   = ovf_reg;
`endif
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=16). Expected results
// come from plain integer addition of the operands sampled at accept.
module tb_serial_adder_ctrl;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         ready;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         ovf;
`endif

  int passed = 0;
  int total  = 0;

  logic [W-1:0] exp_sum  = '0;
  logic         exp_cout = 1'b0;
  logic         exp_ovf  = 1'b0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  // Reference: integer add of the accepted operands
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv);
    logic [W:0] full;
    full     = {1'b0, av} + {1'b0, bv};
    exp_sum  = full[W-1:0];
    exp_cout = full[W];
    exp_ovf  = (av[W-1] == bv[W-1]) && (full[W-1] != av[W-1]);
  endtask

  task automatic check_result(input string tag);
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check({tag, "_cout"}, 32'(cout), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
    check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
`endif
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_before_accept", 32'(ready), 32'd1);
  endtask

  // One add; optionally pulse start with other operands mid-RUN
  task automatic run_add(input logic [W-1:0] av, input logic [W-1:0] bv, input bit mid_pulse);
    int busy_cnt;
    wait_ready();
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = W'($urandom); b = W'($urandom);
    busy_cnt = 0;
    while (busy && busy_cnt < 40) begin
      check("sum_holds_in_run", 32'(sum), 32'(exp_sum));
      if (mid_pulse && busy_cnt == 5) begin
        start = 1'b1; a = ~av; b = 16'h1111;
      end else begin
        start = 1'b0;
      end
      busy_cnt++;
      @(negedge clk);
    end
    start = 1'b0;
    model(av, bv);
    $display("add a=%h b=%h busy=%0d sum=%h cout=%b", av, bv, busy_cnt, sum, cout);
    check("busy_cycles", 32'(busy_cnt), 32'd16);
    check("done_pulse", 32'(done), 32'd1);
    check_result("add");
    @(negedge clk);
    check("done_one_cycle", 32'(done), 32'd0);
    check("ready_after_done", 32'(ready), 32'd1);
  endtask

  initial begin
    int busy_cnt;
    int done_seen;
    int t;
    int ndone;
    int acc_t[$];
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset for 5 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_ready", 32'(ready), 32'd1);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_done", 32'(done), 32'd0);
      check("idle_sum", 32'(sum), 32'd0);
      check("idle_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
      check("idle_ovf", 32'(ovf), 32'd0);
`endif
    end

    // Directed cases
    run_add(16'h0003, 16'h0005, 1'b0);
    run_add(16'h0102, 16'h0304, 1'b1);   // mid-RUN start ignored, 0008 held
    run_add(16'hFFFF, 16'h0001, 1'b0);
    run_add(16'h7FFF, 16'h0001, 1'b0);
    run_add(16'h8000, 16'h8000, 1'b0);

    // Reset during RUN aborts with no done pulse
    wait_ready();
    a = 16'h00FF; b = 16'h0101; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0;
    while (busy && busy_cnt < 9) begin
      busy_cnt++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
    $display("reset mid-run after %0d busy cycles sum=%h ready=%b", busy_cnt, sum, ready);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check_result("rst");
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    check("rst_no_done", 32'(done_seen), 32'd0);
    run_add(16'h1234, 16'h4321, 1'b0);

    // start held high: accepts every 18 cycles, operands from accept edge
    start = 1'b1; t = 0; ndone = 0;
    while (ndone < 3 && t < 200) begin
      if (done) begin
        model(qa.pop_front(), qb.pop_front());
        $display("held add %0d sum=%h cout=%b", ndone, sum, cout);
        check_result("held");
        ndone++;
      end
      if (ndone < 3) begin
        a = W'($urandom); b = W'($urandom);
        if (ready) begin
          acc_t.push_back(t);
          qa.push_back(a);
          qb.push_back(b);
        end
        @(negedge clk);
        t++;
      end
    end
    start = 1'b0;
    check("held_done_count", 32'(ndone), 32'd3);
    if (acc_t.size() >= 3) begin
      check("held_spacing_1", 32'(acc_t[1] - acc_t[0]), 32'd18);
      check("held_spacing_2", 32'(acc_t[2] - acc_t[1]), 32'd18);
    end else begin
      check("held_accept_count", 32'(acc_t.size()), 32'd3);
    end
    @(negedge clk);

    // Random operands
    for (int i = 0; i < 6; i++) begin
      run_add(W'($urandom), W'($urandom), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
